fpu_mds_issue: RTL and testbench

Issue/collect front end for the FPU multiply/divide/square-root unit (`fpu_mds_top`); it drives that unit's request side and consumes its completion side. It accepts raw IEEE-754 single-precision operands from the core over a valid/ready handshake and resolves the rounding mode. It unpacks and classifies the operands, holds them stable while pulsing `start`, then waits for `muldiv_sqrt_done`. It captures the result and exception flags and returns them to the core over a second valid/ready handshake, with kill/drain support.

---
 rtl/fpu_pkg.sv | 47 ++++
 rtl/fpu_unpack.sv | 31 +++
 rtl/fpu_mds_issue.sv | 185 ++++++++++++++++++
 tb/tb_fpu_mds_issue.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU mul/div/sqrt issue path: op codes, rounding
// modes, the canonical NaN, fflags positions and the unpacked-operand record.
package fpu_pkg;

  localparam logic [1:0] MDS_MUL  = 2'b00;
  localparam logic [1:0] MDS_DIV  = 2'b01;
  localparam logic [1:0] MDS_SQRT = 2'b10;
  localparam logic [1:0] MDS_ILL  = 2'b11;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;
  localparam logic [4:0] FFLAG_NV_MASK = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } operand_t;

  function automatic logic rm_is_legal(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Combinational classifier for one raw IEEE-754 single-precision operand.
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] operand_i,
  output operand_t    fields_o,
  output logic        quiet_o
);

  logic [7:0]  exp_s;
  logic [22:0] mant_s;
  logic        exp_max_s;

  assign exp_s     = operand_i[30:23];
  assign mant_s    = operand_i[22:0];
  assign exp_max_s = (exp_s == 8'hFF);

  // Hidden bit is set only for normal numbers; subnormals keep a zero lead bit.
  always_comb begin
    fields_o         = '0;
    fields_o.sign    = operand_i[31];
    fields_o.exp     = exp_s;
    fields_o.sig     = {(exp_s != 8'h00), mant_s};
    fields_o.is_zero = (exp_s == 8'h00) && (mant_s == 23'd0);
    fields_o.is_inf  = exp_max_s && (mant_s == 23'd0);
    fields_o.is_nan  = exp_max_s && (mant_s != 23'd0);
  end

  assign quiet_o = mant_s[22];

endmodule

// File: rtl/fpu_mds_issue.sv
// Issue/collect front end for the FPU mul/div/sqrt unit: accepts core requests,
// drives the unit with classified operands and returns its result to the core.
module fpu_mds_issue
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic [2:0]  frm,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_fflags,
  output logic        resp_illegal,
  output logic        start,
  output logic [1:0]  mds_op,
  output logic [2:0]  rounding_mode,
  output logic        subnormal_sqrt_in,
  output logic        isZeroA,
  output logic        isZeroB,
  output logic        isInfA,
  output logic        isInfB,
  output logic        isNaNA,
  output logic        isNaNB,
  output logic        isSignaling,
  output logic        sign_A,
  output logic        sign_B,
  output logic [7:0]  exp_A,
  output logic [7:0]  exp_B,
  output logic [23:0] sig_A,
  output logic [23:0] sig_B,
  input  logic [31:0] OUT,
  input  logic        muldiv_sqrt_done,
  input  logic        overflow,
  input  logic        underflow,
  input  logic        invalid,
  input  logic        inexact,
  input  logic        div_by_zero
);

  state_e      state_q, state_d;
  operand_t    unp_a_s, unp_b_s, opb_s;
  operand_t    opa_q, opb_q;
  logic        quiet_a_s, quiet_b_s;
  logic [1:0]  op_q;
  logic [2:0]  rm_q, rm_res_s;
  logic        sub_sqrt_q, signaling_q;
  logic        rm_bad_s, op_bad_s, is_sqrt_s;
  logic        load_ops_s, load_fast_s, capture_s;
  logic [31:0] resp_result_q;
  logic [4:0]  resp_fflags_q, done_flags_s;
  logic        resp_illegal_q;

  fpu_unpack u_unpack_a (.operand_i(req_a), .fields_o(unp_a_s), .quiet_o(quiet_a_s));
  fpu_unpack u_unpack_b (.operand_i(req_b), .fields_o(unp_b_s), .quiet_o(quiet_b_s));

  assign rm_res_s  = (req_rm == RM_DYN) ? frm : req_rm;
  assign rm_bad_s  = !rm_is_legal(rm_res_s);
  assign op_bad_s  = (req_op == MDS_ILL);
  assign is_sqrt_s = (req_op == MDS_SQRT);
  assign opb_s     = is_sqrt_s ? '0 : unp_b_s;

  // Map the unit's individual exception lines onto the fflags layout.
  always_comb begin
    done_flags_s           = 5'b00000;
    done_flags_s[FFLAG_NV] = invalid;
    done_flags_s[FFLAG_DZ] = div_by_zero;
    done_flags_s[FFLAG_OF] = overflow;
    done_flags_s[FFLAG_UF] = underflow;
    done_flags_s[FFLAG_NX] = inexact;
  end

  // Next-state logic; a kill coinciding with done skips DRAIN since nothing is left to wait for.
  always_comb begin
    state_d     = state_q;
    load_ops_s  = 1'b0;
    load_fast_s = 1'b0;
    capture_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (rm_bad_s || op_bad_s) begin
            state_d     = ST_RESP;
            load_fast_s = 1'b1;
          end else begin
            state_d    = ST_START;
            load_ops_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_WAIT: begin
        if (kill) begin
          state_d = muldiv_sqrt_done ? ST_IDLE : ST_DRAIN;
        end else if (muldiv_sqrt_done) begin
          state_d   = ST_RESP;
          capture_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (muldiv_sqrt_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_RESP: begin
        if (kill || resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, held unit-side operands and the captured response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      opa_q          <= '0;
      opb_q          <= '0;
      op_q           <= 2'b00;
      rm_q           <= 3'b000;
      sub_sqrt_q     <= 1'b0;
      signaling_q    <= 1'b0;
      resp_result_q  <= 32'h0000_0000;
      resp_fflags_q  <= 5'b00000;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_ops_s) begin
        opa_q       <= unp_a_s;
        opb_q       <= opb_s;
        op_q        <= req_op;
        rm_q        <= rm_res_s;
        sub_sqrt_q  <= is_sqrt_s && (unp_a_s.exp == 8'h00) && !unp_a_s.is_zero;
        signaling_q <= (unp_a_s.is_nan && !quiet_a_s) || (opb_s.is_nan && !quiet_b_s);
      end
      if (load_fast_s) begin
        resp_result_q  <= rm_bad_s ? 32'h0000_0000 : CANON_NAN;
        resp_fflags_q  <= rm_bad_s ? 5'b00000 : FFLAG_NV_MASK;
        resp_illegal_q <= rm_bad_s;
      end else if (capture_s) begin
        resp_result_q  <= OUT;
        resp_fflags_q  <= done_flags_s;
        resp_illegal_q <= 1'b0;
      end
    end
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign start             = (state_q == ST_START);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_result       = resp_result_q;
  assign resp_fflags       = resp_fflags_q;
  assign resp_illegal      = resp_illegal_q;
  assign mds_op            = op_q;
  assign rounding_mode     = rm_q;
  assign subnormal_sqrt_in = sub_sqrt_q;
  assign isSignaling       = signaling_q;
  assign sign_A            = opa_q.sign;
  assign exp_A             = opa_q.exp;
  assign sig_A             = opa_q.sig;
  assign isZeroA           = opa_q.is_zero;
  assign isInfA            = opa_q.is_inf;
  assign isNaNA            = opa_q.is_nan;
  assign sign_B            = opb_q.sign;
  assign exp_B             = opb_q.exp;
  assign sig_B             = opb_q.sig;
  assign isZeroB           = opb_q.is_zero;
  assign isInfB            = opb_q.is_inf;
  assign isNaNB            = opb_q.is_nan;

endmodule

// File: tb/tb_fpu_mds_issue.sv
// Randomized scoreboard bench for fpu_mds_issue with a stand-in unit model.
module tb_fpu_mds_issue;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, kill, resp_valid, resp_ready, resp_illegal;
  logic [1:0] req_op, mds_op;
  logic [2:0] req_rm, frm, rounding_mode;
  logic [31:0] req_a, req_b, resp_result, OUT;
  logic [4:0] resp_fflags;
  logic start, subnormal_sqrt_in, isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB;
  logic isSignaling, sign_A, sign_B;
  logic [7:0] exp_A, exp_B;
  logic [23:0] sig_A, sig_B;
  logic muldiv_sqrt_done, overflow, underflow, invalid, inexact, div_by_zero;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  bit rr_rand = 1'b1;

  always #5 clk = ~clk;

  fpu_mds_issue dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .frm(frm), .req_a(req_a), .req_b(req_b),
    .kill(kill), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_fflags(resp_fflags), .resp_illegal(resp_illegal),
    .start(start), .mds_op(mds_op), .rounding_mode(rounding_mode),
    .subnormal_sqrt_in(subnormal_sqrt_in), .isZeroA(isZeroA), .isZeroB(isZeroB),
    .isInfA(isInfA), .isInfB(isInfB), .isNaNA(isNaNA), .isNaNB(isNaNB),
    .isSignaling(isSignaling), .sign_A(sign_A), .sign_B(sign_B),
    .exp_A(exp_A), .exp_B(exp_B), .sig_A(sig_A), .sig_B(sig_B),
    .OUT(OUT), .muldiv_sqrt_done(muldiv_sqrt_done), .overflow(overflow),
    .underflow(underflow), .invalid(invalid), .inexact(inexact), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    chk(name, {31'd0, act}, {31'd0, want});
  endtask

  function automatic exp_t mk_exp(input logic [31:0] r, input logic [4:0] f, input logic i);
    exp_t e;
    e.res = r;
    e.fl  = f;
    e.ill = i;
    return e;
  endfunction

  task automatic drive_unit(input logic [31:0] o, input logic [4:0] f);
    OUT = o;
    {invalid, div_by_zero, overflow, underflow, inexact} = f;
  endtask

  // One clock: inputs change only at the falling edge; idle unit lines carry noise.
  task automatic tick();
    @(negedge clk);
    if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
    if (!muldiv_sqrt_done) drive_unit($urandom, 5'($urandom));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    if (!req_ready) chk1("req_ready_timeout", req_ready, 1'b1);
  endtask

  // Expected unit-side fields from the IEEE-754 field definitions.
  task automatic check_fields(input logic [1:0] op, input logic [2:0] rrm,
                              input logic [31:0] a, input logic [31:0] b);
    int unsigned ea, ma, eb, mb;
    bit sq, nan_a, nan_b;
    sq    = (op == MDS_SQRT);
    ea    = (a >> 23) % 256;
    ma    = a % 32'h0080_0000;
    eb    = sq ? 0 : (b >> 23) % 256;
    mb    = sq ? 0 : b % 32'h0080_0000;
    nan_a = (ea == 255) && (ma != 0);
    nan_b = !sq && (eb == 255) && (mb != 0);
    chk("mds_op", {30'd0, mds_op}, {30'd0, op});
    chk("rounding_mode", {29'd0, rounding_mode}, {29'd0, rrm});
    chk1("sign_A", sign_A, a[31]);
    chk("exp_A", {24'd0, exp_A}, ea);
    chk("sig_A", {8'd0, sig_A}, (ea != 0) ? ma + 32'h0080_0000 : ma);
    chk1("isZeroA", isZeroA, (ea == 0) && (ma == 0));
    chk1("isInfA", isInfA, (ea == 255) && (ma == 0));
    chk1("isNaNA", isNaNA, nan_a);
    chk1("sign_B", sign_B, !sq && b[31]);
    chk("exp_B", {24'd0, exp_B}, eb);
    chk("sig_B", {8'd0, sig_B}, (eb != 0) ? mb + 32'h0080_0000 : mb);
    chk1("isZeroB", isZeroB, !sq && (eb == 0) && (mb == 0));
    chk1("isInfB", isInfB, !sq && (eb == 255) && (mb == 0));
    chk1("isNaNB", isNaNB, nan_b);
    chk1("isSignaling", isSignaling, (nan_a && ((a >> 22) % 2 == 0)) || (nan_b && ((b >> 22) % 2 == 0)));
    chk1("subnormal_sqrt_in", subnormal_sqrt_in, sq && (ea == 0) && (ma != 0));
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_ctl"}, {13'd0, start, resp_valid, resp_illegal, mds_op, rounding_mode,
        subnormal_sqrt_in, isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB, isSignaling,
        sign_A, sign_B}, 32'd0);
    chk({tag, "_resp"}, resp_result | {27'd0, resp_fflags}, 32'd0);
    chk({tag, "_fields_A"}, {exp_A, sig_A}, 32'd0);
    chk({tag, "_fields_B"}, {exp_B, sig_B}, 32'd0);
  endtask

  // Issue one request and play the unit's side; leaves the response for the monitor.
  task automatic do_op(input logic [1:0] op, input logic [2:0] rm, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b, input int lat,
                       input logic [31:0] out_v, input logic [4:0] fl_v);
    logic [2:0] rrm;
    bit fast;
    rrm = (rm == RM_DYN) ? f : rm;
    wait_ready();
    req_valid = 1'b1; req_op = op; req_rm = rm; frm = f; req_a = a; req_b = b;
    fast = 1'b1;
    if (rrm > RM_RMM) sb.push_back(mk_exp(32'h0, 5'b00000, 1'b1));
    else if (op == MDS_ILL) sb.push_back(mk_exp(32'h7FC0_0000, 5'b10000, 1'b0));
    else fast = 1'b0;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; frm = 3'($urandom);
    if (fast) begin
      chk1("fast_resp_valid", resp_valid, 1'b1);
      chk1("fast_no_start", start, 1'b0);
      return;
    end
    chk1("start_T1", start, 1'b1);
    check_fields(op, rrm, a, b);
    if (lat > 0) begin
      tick();
      chk1("start_single", start, 1'b0);
      chk1("wait_no_resp", resp_valid, 1'b0);
      for (int i = 1; i < lat; i++) tick();
    end
    muldiv_sqrt_done = 1'b1;
    drive_unit(out_v, fl_v);
    sb.push_back(mk_exp(out_v, fl_v, 1'b0));
    tick();
    muldiv_sqrt_done = 1'b0;
    chk1("resp_valid_D1", resp_valid, 1'b1);
    chk1("start_after_done", start, 1'b0);
  endtask

  // Monitor: every response handshake is matched against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", resp_result, 32'hDEAD_0000 ^ resp_result ^ 32'h1);
        end else begin
          e = sb.pop_front();
          chk("resp_result", resp_result, e.res);
          chk("resp_fflags", {27'd0, resp_fflags}, {27'd0, e.fl});
          chk1("resp_illegal", resp_illegal, e.ill);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] specials [11] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0000, 32'h7F80_0001, 32'h7FA0_0000, 32'h0000_0001,
                                 32'h007F_FFFF, 32'h3F80_0000, 32'h0080_0000};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 10)];
    else return $urandom;
  endfunction

  initial begin : stimulus
    logic [1:0] op;
    logic [2:0] rm;
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_rm = 3'b000; frm = 3'b000;
    req_a = 32'h0; req_b = 32'h0; kill = 1'b0; resp_ready = 1'b0;
    muldiv_sqrt_done = 1'b0; drive_unit(32'h0, 5'b00000);
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b1;
    tick();

    do_op(MDS_MUL, RM_RNE, 3'd0, 32'h4000_0000, 32'h4040_0000, 3, 32'h40C0_0000, 5'b00000);
    do_op(MDS_SQRT, RM_RTZ, 3'd0, 32'h0000_0001, 32'h7F80_0001, 2, 32'h1234_0000, 5'b00001);
    do_op(MDS_MUL, RM_RNE, 3'd0, 32'h7F80_0001, 32'h3F80_0000, 1, 32'h7FC0_0000, 5'b10000);
    do_op(MDS_ILL, RM_RNE, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 0, 32'h0, 5'b00000);
    do_op(MDS_DIV, RM_DYN, 3'd5, 32'h3F80_0000, 32'h0000_0000, 0, 32'h0, 5'b00000);
    do_op(MDS_DIV, RM_DYN, 3'd3, 32'h3F80_0000, 32'h0000_0000, 0, 32'h7F80_0000, 5'b01000);

    // Response held by the core while the unit lines keep changing.
    wait_ready();
    rr_rand = 1'b0; resp_ready = 1'b0;
    do_op(MDS_MUL, RM_RUP, 3'd0, 32'h3F80_0000, 32'h4000_0000, 2, 32'h1234_5678, 5'b00101);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      if (c == 4) resp_ready = 1'b1;
      chk1("hold_valid", resp_valid, 1'b1);
      chk("hold_result", resp_result, 32'h1234_5678);
      chk("hold_fflags", {27'd0, resp_fflags}, 32'd5);
    end
    tick();
    chk1("hold_released", req_ready, 1'b1);
    chk1("hold_no_valid", resp_valid, 1'b0);
    rr_rand = 1'b1;

    // Kill two cycles into WAIT, then a late done that must be swallowed.
    wait_ready();
    req_valid = 1'b1; req_op = MDS_DIV; req_rm = RM_RTZ; req_a = 32'h4120_0000; req_b = 32'h40A0_0000;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    chk1("kill_start", start, 1'b1);
    tick();
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    for (int i = 0; i < 10; i++) begin
      kill = (i == 3);
      chk1("drain_not_ready", req_ready, 1'b0);
      chk1("drain_no_resp", resp_valid, 1'b0);
      check_fields(MDS_DIV, RM_RTZ, 32'h4120_0000, 32'h40A0_0000);
      if (i == 9) muldiv_sqrt_done = 1'b1;
      tick();
    end
    muldiv_sqrt_done = 1'b0; kill = 1'b0;
    chk1("ready_after_drain", req_ready, 1'b1);
    chk1("no_resp_after_drain", resp_valid, 1'b0);

    // Kill and done together: kill wins, no response.
    req_valid = 1'b1; req_op = MDS_MUL; req_rm = RM_RNE; req_a = $urandom; req_b = $urandom;
    tick();
    req_valid = 1'b0;
    kill = 1'b1; muldiv_sqrt_done = 1'b1;
    tick();
    kill = 1'b0; muldiv_sqrt_done = 1'b0;
    chk1("kill_done_ready", req_ready, 1'b1);
    chk1("kill_done_no_resp", resp_valid, 1'b0);

    // Reset in the middle of an operation; the stale done is ignored.
    req_valid = 1'b1; req_op = MDS_MUL; req_rm = RM_RDN; req_a = $urandom; req_b = $urandom;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_reset_state("midop_reset");
    tick();
    reset = 1'b1;
    muldiv_sqrt_done = 1'b1;
    tick();
    muldiv_sqrt_done = 1'b0;
    chk1("stale_done_ignored", resp_valid, 1'b0);
    chk1("stale_done_ready", req_ready, 1'b1);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: op = MDS_MUL;
        3, 4:    op = MDS_DIV;
        5, 6:    op = MDS_SQRT;
        default: op = MDS_ILL;
      endcase
      rm = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      do_op(op, rm, 3'($urandom), pick_operand(), pick_operand(),
            int'($urandom_range(0, 6)), $urandom, 5'($urandom));
    end

    wait_ready();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
